// File: rtl/cardinal_run_monitor.sv
// Run controller for a Cardinal node array: releases node resets, times each node to its
// terminating NOP, waits out the pipeline flush, then streams every node's data memory.
module cardinal_run_monitor #(
  parameter int NODES      = 4,
  parameter int INSTR_W    = 32,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 64,
  parameter int DUMP_DEPTH = 128,
  parameter int RESET_CYC  = 5,
  parameter int FLUSH_CYC  = 5,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 0,
  localparam int NW        = (NODES > 1) ? $clog2(NODES) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [NODES*INSTR_W-1:0] instr_i,
  output logic [NODES-1:0]         node_reset_o,
  output logic [NODES-1:0]         node_done_o,
  output logic [NODES*CNT_W-1:0]   node_cycles_o,
  output logic                     busy_o,
  output logic                     timed_out_o,
  output logic                     dump_en_o,
  output logic [NW-1:0]            dump_node_o,
  output logic [ADDR_W-1:0]        dump_addr_o,
  input  logic [DATA_W-1:0]        dump_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [NW-1:0]            out_node_o,
  output logic [ADDR_W-1:0]        out_addr_o,
  output logic [DATA_W-1:0]        out_data_o,
  output logic                     all_done_o
);
  // state | meaning
  // IDLE  | nodes held in reset, waiting for start
  // HOLD  | nodes held in reset for RESET_CYC cycles, results cleared
  // RUN   | nodes executing, per-node cycle counting until NOP or timeout
  // FLUSH | nodes free-running for FLUSH_CYC cycles to drain pipelines
  // DUMP  | sweeping data memories, one read in flight at most
  // DONE  | results held, waiting for a re-run start

  localparam int TMAX1    = (RESET_CYC > FLUSH_CYC) ? RESET_CYC : FLUSH_CYC;
  localparam int TMAX2    = (TMAX1 > TIMEOUT) ? TMAX1 : TIMEOUT;
  localparam int TMAX     = (TMAX2 > 2) ? TMAX2 : 2;
  localparam int TW       = $clog2(TMAX);
  localparam int RUN_LOAD = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RUN, S_FLUSH, S_DUMP, S_DONE} state_e;

  state_e                        state_q, state_d;
  logic [TW-1:0]                 tmr_q, tmr_d;
  logic [NODES-1:0]              done_q, done_d;
  logic [NODES-1:0][CNT_W-1:0]   cyc_q, cyc_d;
  logic                          timed_q, timed_d;
  logic [NW-1:0]                 dnode_q, dnode_d;
  logic [ADDR_W-1:0]             daddr_q, daddr_d;
  logic                          last_q, last_d;
  logic                          pend_q, pend_d;
  logic                          ov_q, ov_d;
  logic [NW-1:0]                 onode_q, onode_d;
  logic [ADDR_W-1:0]             oaddr_q, oaddr_d;
  logic [DATA_W-1:0]             odata_q, odata_d;
  logic                          issue;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      done_q  <= '0;
      cyc_q   <= '0;
      timed_q <= 1'b0;
      dnode_q <= '0;
      daddr_q <= '0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      ov_q    <= 1'b0;
      onode_q <= '0;
      oaddr_q <= '0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      done_q  <= done_d;
      cyc_q   <= cyc_d;
      timed_q <= timed_d;
      dnode_q <= dnode_d;
      daddr_q <= daddr_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      ov_q    <= ov_d;
      onode_q <= onode_d;
      oaddr_q <= oaddr_d;
      odata_q <= odata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    done_d  = done_q;
    cyc_d   = cyc_q;
    timed_d = timed_q;
    dnode_d = dnode_q;
    daddr_d = daddr_q;
    last_d  = last_q;
    pend_d  = pend_q;
    ov_d    = ov_q;
    onode_d = onode_q;
    oaddr_d = oaddr_q;
    odata_d = odata_q;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_HOLD;
          tmr_d   = TW'(RESET_CYC - 1);
          done_d  = '0;
          cyc_d   = '0;
          timed_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (tmr_q == '0) begin
          state_d = S_RUN;
          tmr_d   = TW'(RUN_LOAD);
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_RUN: begin
        for (int n = 0; n < NODES; n++) begin
          if (!done_q[n]) begin
            if (instr_i[n*INSTR_W +: INSTR_W] == '0) done_d[n] = 1'b1;
            else if (cyc_q[n] != '1) cyc_d[n] = cyc_q[n] + 1'b1;
          end
        end
        // Completion on the same edge as the limit wins over the timeout.
        if (&done_d) begin
          state_d = S_FLUSH;
          tmr_d   = TW'(FLUSH_CYC - 1);
        end else if (TIMEOUT != 0 && tmr_q == '0) begin
          state_d = S_FLUSH;
          tmr_d   = TW'(FLUSH_CYC - 1);
          timed_d = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_FLUSH: begin
        if (tmr_q == '0) begin
          state_d = S_DUMP;
          dnode_d = '0;
          daddr_d = '0;
          last_d  = 1'b0;
          pend_d  = 1'b0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_DUMP: begin
        if (ov_q && out_ready_i) ov_d = 1'b0;
        if (pend_q) begin
          odata_d = dump_data_i;
          ov_d    = 1'b1;
          pend_d  = 1'b0;
        end else if (!last_q) begin
          // Node/addr tag moves at issue; the old record is gone or leaving this cycle.
          if (!ov_q || out_ready_i) begin
            issue   = 1'b1;
            pend_d  = 1'b1;
            onode_d = dnode_q;
            oaddr_d = daddr_q;
            if (daddr_q == ADDR_W'(DUMP_DEPTH - 1)) begin
              daddr_d = '0;
              if (dnode_q == NW'(NODES - 1)) last_d = 1'b1;
              else dnode_d = dnode_q + 1'b1;
            end else begin
              daddr_d = daddr_q + 1'b1;
            end
          end
        end else if (ov_q && out_ready_i) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign node_reset_o  = {NODES{(state_q == S_IDLE) || (state_q == S_HOLD)}};
  assign node_done_o   = done_q;
  assign node_cycles_o = cyc_q;
  assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign timed_out_o   = timed_q;
  assign dump_en_o     = issue;
  assign dump_node_o   = dnode_q;
  assign dump_addr_o   = daddr_q;
  assign out_valid_o   = ov_q;
  assign out_node_o    = onode_q;
  assign out_addr_o    = oaddr_q;
  assign out_data_o    = odata_q;
  assign all_done_o    = (state_q == S_DONE);

endmodule

// File: tb/tb_cardinal_run_monitor.sv
// Scoreboard bench for cardinal_run_monitor: randomized node programs and sink backpressure,
// expected run results and dump records derived from the run rules.
module tb_cardinal_run_monitor;
  localparam int NODES = 2, INSTR_W = 32, ADDR_W = 8, DATA_W = 64, DUMP_DEPTH = 128;
  localparam int RESET_CYC = 5, FLUSH_CYC = 5, CNT_W = 32, TIMEOUT = 50, NW = 1;
  localparam int NREC = NODES * DUMP_DEPTH;
  localparam int NEVER = 1000000;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic [NODES*INSTR_W-1:0] instr = '0;
  logic [NODES-1:0]         node_reset, node_done;
  logic [NODES*CNT_W-1:0]   node_cycles;
  logic                     busy, timed_out, dump_en, out_valid, all_done;
  logic                     out_ready = 1'b0;
  logic [NW-1:0]            dump_node, out_node;
  logic [ADDR_W-1:0]        dump_addr, out_addr;
  logic [DATA_W-1:0]        dump_data = '0;
  logic [DATA_W-1:0]        out_data;

  cardinal_run_monitor #(
    .NODES(NODES), .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .DUMP_DEPTH(DUMP_DEPTH), .RESET_CYC(RESET_CYC), .FLUSH_CYC(FLUSH_CYC),
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .instr_i(instr),
    .node_reset_o(node_reset), .node_done_o(node_done), .node_cycles_o(node_cycles),
    .busy_o(busy), .timed_out_o(timed_out), .dump_en_o(dump_en),
    .dump_node_o(dump_node), .dump_addr_o(dump_addr), .dump_data_i(dump_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_node_o(out_node),
    .out_addr_o(out_addr), .out_data_o(out_data), .all_done_o(all_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NW-1:0]     node;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rec_t;

  rec_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] salt = 32'h0;
  int          len[NODES];
  int          ready_mode = 0;
  int          acc_total = 0;
  int          acc_time[4096];

  function automatic logic [63:0] mem_word(logic [31:0] s, logic [NW-1:0] n, logic [ADDR_W-1:0] a);
    return {s, 16'(n), 16'(a)};
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Node program: after reset release, fetch len[n] nonzero words and then NOPs forever.
  int fetch_k[NODES];
  always @(negedge clk) begin
    for (int n = 0; n < NODES; n++) begin
      if (node_reset[n]) begin
        fetch_k[n] = 0;
        instr[n*INSTR_W +: INSTR_W] = $urandom | 32'h1;
      end else begin
        instr[n*INSTR_W +: INSTR_W] = (fetch_k[n] < len[n]) ? ($urandom | 32'h1) : 32'h0;
        fetch_k[n]++;
      end
    end
  end

  // Synchronous-read data memory: data for a request appears in the following cycle only.
  logic              mem_req = 1'b0;
  logic [NW-1:0]     mem_node = '0;
  logic [ADDR_W-1:0] mem_addr = '0;
  always @(negedge clk) begin
    mem_req  = dump_en;
    mem_node = dump_node;
    mem_addr = dump_addr;
  end
  always @(posedge clk) begin
    #1;
    if (mem_req) dump_data = mem_word(salt, mem_node, mem_addr);
    else dump_data = {$urandom, $urandom};
  end

  // Sink: mode 0 always ready, 1 random, 2 random with periodic 20-cycle stalls.
  int stall_left = 0;
  int last_trig = -1;
  always @(posedge clk) begin
    #1;
    if (ready_mode == 2 && stall_left == 0 && acc_total != last_trig && acc_total % 64 == 40) begin
      stall_left = 20;
      last_trig  = acc_total;
    end
    if (ready_mode == 0) out_ready = 1'b1;
    else if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else out_ready = ($urandom_range(0, 99) < 65);
  end

  // Monitor: pops expected records on each handshake, checks hold-while-stalled and read spacing.
  int                cyc = 0;
  logic              prev_stall = 1'b0;
  logic              prev_en = 1'b0;
  logic [NW-1:0]     hold_node;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  always @(negedge clk) begin
    rec_t r;
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_en    = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_fields", 64'({out_valid, out_node, out_addr}), 64'({1'b1, hold_node, hold_addr}));
        check("hold_data", out_data, hold_data);
      end
      if (dump_en) check("single_outstanding", 64'(prev_en), 64'(0));
      if (out_valid && out_ready) begin
        if (acc_total < 4096) acc_time[acc_total] = cyc;
        acc_total++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL extra_record node=%0d addr=%0d (none expected)", out_node, out_addr);
        end else begin
          r = exp_q.pop_front();
          check("rec_node", 64'(out_node), 64'(r.node));
          check("rec_addr", 64'(out_addr), 64'(r.addr));
          check("rec_data", out_data, r.data);
        end
      end
      prev_stall = out_valid && !out_ready;
      hold_node  = out_node;
      hold_addr  = out_addr;
      hold_data  = out_data;
      prev_en    = dump_en;
    end
  end

  task automatic check_reset_values(string tag);
    check({tag, "_node_reset"}, 64'(node_reset), 64'({NODES{1'b1}}));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_dump_en"}, 64'(dump_en), 64'(0));
    check({tag, "_all_done"}, 64'(all_done), 64'(0));
    check({tag, "_node_done"}, 64'(node_done), 64'(0));
    check({tag, "_node_cycles"}, 64'(node_cycles), 64'(0));
    check({tag, "_timed_out"}, 64'(timed_out), 64'(0));
    check({tag, "_dump_ptr"}, 64'({dump_node, dump_addr}), 64'(0));
  endtask

  // One run: derive the expected outcome from the node programs, start, and follow it through.
  task automatic run(int l0, int l1, int mode, bit poke_start, int abort_at);
    int mx, r_edges, k, t, base;
    bit exp_timed;
    int exp_cyc[NODES];
    logic [NODES-1:0] exp_done;
    len[0] = l0;
    len[1] = l1;
    mx = (l0 > l1) ? l0 : l1;
    exp_timed = (TIMEOUT != 0) && (mx + 1 > TIMEOUT);
    r_edges = exp_timed ? TIMEOUT : mx + 1;
    for (int n = 0; n < NODES; n++) begin
      exp_done[n] = len[n] < r_edges;
      exp_cyc[n]  = (len[n] < r_edges) ? len[n] : r_edges;
    end
    salt = $urandom;
    ready_mode = mode;
    exp_q.delete();
    for (int n = 0; n < NODES; n++)
      for (int a = 0; a < DUMP_DEPTH; a++)
        exp_q.push_back('{node: NW'(n), addr: ADDR_W'(a), data: mem_word(salt, NW'(n), ADDR_W'(a))});
    base = acc_total;

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("hold_node_reset", 64'(node_reset), 64'({NODES{1'b1}}));
    check("hold_busy", 64'(busy), 64'(1));
    k = 0;
    while (!dump_en && k < 3000) begin
      @(negedge clk);
      k++;
      start = poke_start && (k == RESET_CYC + 2);
    end
    start = 1'b0;
    check("start_to_dump_cycles", 64'(k), 64'(RESET_CYC + r_edges + FLUSH_CYC));
    check("dump_node_reset", 64'(node_reset), 64'(0));
    check("node_done", 64'(node_done), 64'(exp_done));
    check("timed_out", 64'(timed_out), 64'(exp_timed));
    for (int n = 0; n < NODES; n++)
      check($sformatf("node_cycles%0d", n), 64'(node_cycles[n*CNT_W +: CNT_W]), 64'(exp_cyc[n]));

    if (abort_at > 0) begin
      t = 0;
      while (acc_total - base < abort_at && t < 5000) begin
        @(negedge clk);
        t++;
      end
      check("abort_point_reached", 64'(acc_total - base >= abort_at), 64'(1));
      #2 rst_n = 1'b0;
      #1 check_reset_values("async_reset");
      exp_q.delete();
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      return;
    end

    t = 0;
    while (!all_done && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("all_done", 64'(all_done), 64'(1));
    check("records_outstanding", 64'(exp_q.size()), 64'(0));
    check("done_busy", 64'(busy), 64'(0));
    check("done_node_done", 64'(node_done), 64'(exp_done));
    check("done_cycles0", 64'(node_cycles[0 +: CNT_W]), 64'(exp_cyc[0]));
    if (mode == 0 && base + NREC - 1 < 4096)
      check("full_rate_span", 64'(acc_time[base + NREC - 1] - acc_time[base]), 64'(2 * (NREC - 1)));
  endtask

  initial begin
    len[0] = 1;
    len[1] = 1;
    repeat (2) @(negedge clk);
    check_reset_values("por");
    @(negedge clk) rst_n = 1'b1;

    run(10, 25, 0, 1'b0, 0);
    run(10, 25, 1, 1'b1, 0);
    run(20, NEVER, 2, 1'b0, 0);
    run(49, 3, 1, 1'b0, 0);
    run(0, 7, 2, 1'b0, 0);
    run(0, 30, 1, 1'b0, 37);
    run(12, 5, 0, 1'b0, 0);
    for (int i = 0; i < 2; i++)
      run($urandom_range(0, 60), $urandom_range(0, 60), $urandom_range(1, 2), 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cardinal_run_monitor.md
Name: cardinal_run_monitor

Overview:
Synthesizable run controller and result harvester for multi-node Cardinal Processor arrays. It performs the following sequence:
- Releases node resets on Start.
- Watches each node's fetched instruction for the terminating NOP (all-zero word) and counts per-node run cycles.
- Waits a pipeline-flush interval after the last node finishes.
- Sweeps every node's data memory, streaming (node, address, data) records over a valid/ready port.

It sits between the node array, the data-memory read ports and an on-chip trace/UART sink, replacing bench-only completion and dump logic.

Parameters:
NODES, 4, number of processor nodes monitored
INSTR_W, 32, instruction width per node
ADDR_W, 8, data-memory address width
DATA_W, 64, data-memory word width
DUMP_DEPTH, 128, words dumped per node, addresses 0..DUMP_DEPTH-1 (DUMP_DEPTH <= 2**ADDR_W)
RESET_CYC, 5, cycles node resets stay asserted after Start
FLUSH_CYC, 5, cycles waited after the last node completes
CNT_W, 32, cycle counter width
TIMEOUT, 0, RUN-cycle limit; 0 disables

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Start  in  1  one-cycle pulse that begins a run
Instruction  in  NODES*INSTR_W  fetched instruction per node; node n occupies slice n*INSTR_W +: INSTR_W
Node_Reset_Out  out  NODES  active-high reset to each node
Node_Done  out  NODES  per-node completion flag
Node_Cycles  out  NODES*CNT_W  per-node cycle count; same slicing as Instruction
Busy  out  1  high in any state other than IDLE and DONE
Timed_Out  out  1  set when TIMEOUT expires
Dump_En  out  1  data-memory read enable
Dump_Node  out  clog2(NODES) (min 1)  node being read
Dump_Addr  out  ADDR_W  read address
Dump_Data  in  DATA_W  read data, valid the cycle after Dump_En
Out_Valid  out  1  record valid
Out_Ready  in  1  sink accepts record
Out_Node  out  clog2(NODES) (min 1)  record node
Out_Addr  out  ADDR_W  record address
Out_Data  out  DATA_W  record data
All_Done  out  1  dump complete; high only in DONE

Behaviour:
- Reset low (async): state=IDLE, Node_Reset_Out=all 1, Node_Done=0, Node_Cycles=0, Busy=0, Timed_Out=0, Dump_En=0, Out_Valid=0, All_Done=0, Dump_Node/Addr=0. Any in-flight dump is abandoned.
- States: IDLE, HOLD, RUN, FLUSH, DUMP, DONE.
- IDLE:
  - Start -> HOLD.
  - Node_Reset_Out stays all 1.
- HOLD:
  - Counts RESET_CYC cycles with Node_Reset_Out all 1, then -> RUN with Node_Reset_Out=0.
  - Entering HOLD clears Node_Done, Node_Cycles, Timed_Out.
- RUN, each edge, per node n with Node_Done[n]=0:
  - Instruction slice == 0 -> Node_Done[n]<=1; the count freezes.
  - Otherwise Node_Cycles[n] increments, saturating at all-ones.
  - A node whose first RUN-cycle instruction is 0 reports 0 cycles.
- RUN exit:
  - All Node_Done bits = 1 -> FLUSH.
  - TIMEOUT != 0 and the RUN cycle counter reaches TIMEOUT first -> Timed_Out<=1, FLUSH. Unfinished nodes keep Done=0 and their current counts.
- FLUSH:
  - FLUSH_CYC cycles; nodes stay out of reset. Then -> DUMP with Dump_Node=0, Dump_Addr=0.
- DUMP read protocol:
  - At most one outstanding read.
  - Dump_En is asserted for one cycle when there is no pending read and the output register is free (Out_Valid=0, or Out_Valid&&Out_Ready this cycle).
  - The next cycle, Dump_Data is captured into Out_Data together with the issued node/addr, and Out_Valid<=1.
  - Peak throughput is one record per 2 cycles.
- DUMP address stepping:
  - Addr increments after each issue.
  - At DUMP_DEPTH-1, addr wraps to 0 and node increments.
  - After node NODES-1 addr DUMP_DEPTH-1 is issued, no further reads; -> DONE once the last record is accepted.
- Out_Valid rules:
  - Once Out_Valid=1, Out_Node/Addr/Data hold stable until Out_Ready.
  - Out_Valid drops on acceptance unless a new capture occurs in the same cycle.
- DONE:
  - All_Done=1; Node_Done, Node_Cycles, Timed_Out hold.
  - Start -> HOLD (re-run).
- Start outside IDLE/DONE is ignored.
- Node_Reset_Out=all 1 in IDLE and HOLD; 0 in RUN, FLUSH, DUMP, DONE.

Test Plan:
- NODES=2. Node0 fetches 10 nonzero words then 0; node1 fetches 25 nonzero then 0 -> Node_Cycles = 10 / 25, Node_Done=2'b11. FLUSH lasts 5 cycles, then DUMP begins.
- Dump with Out_Ready tied high and dmem[n][a]={n,a} pattern -> 2*128 records in order node0 a0..a127 then node1; Out_Data matches; All_Done after the last record; one record per 2 cycles.
- Random Out_Ready backpressure (including 20-cycle stall) -> Out_* stable while Valid&&!Ready; no record lost or duplicated; Dump_En never asserted with an outstanding read.
- TIMEOUT=50, node1 never fetches 0 -> Timed_Out=1 at RUN cycle 50, Node_Done=2'b01, Node_Cycles[1]=50, dump still completes.
- Reset asserted low mid-DUMP (record 37) -> all outputs at reset values immediately (async), Node_Reset_Out=all 1. A new Start reruns cleanly from address 0.
- Start pulsed during RUN -> ignored. Start in DONE -> counters cleared, HOLD 5 cycles, identical results on identical stimulus.
